// File: rtl/sorter_pkg.sv
// Shared constants for the odd-even sorter loader/unloader pair: frame geometry
// defaults and the two-state framing FSM encoding.
package sorter_pkg;

  localparam int SORT_N_WORDS = 8;
  localparam int SORT_WORD_W  = 8;
  localparam int SORT_IDX_W   = $clog2(SORT_N_WORDS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/sorter_unloader.sv
// Output serializer for the odd-even sorter: captures a sorted frame in one cycle
// and streams it word by word over a valid/ready port, ascending or descending.
module sorter_unloader
  import sorter_pkg::*;
#(
  parameter int N_WORDS = SORT_N_WORDS,
  parameter int WORD_W  = SORT_WORD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_valid,
  input  logic [N_WORDS*WORD_W-1:0]   frame_data,
  input  logic                        dir,
  output logic                        frame_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        overrun
);

  localparam int IDX_W = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

  logic [0:0]        state;
  logic [WORD_W-1:0] buffer [N_WORDS];
  logic              dir_q;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cnt;
  logic              xfer;
  logic              is_last;

  // Outputs decode only from registered state, so out_ready never reaches them.
  assign out_valid   = (state == ST_STREAM);
  assign frame_ready = (state == ST_IDLE);
  assign is_last     = (cnt == IDX_LAST);
  assign out_last    = out_valid && is_last;
  assign out_data    = out_valid ? buffer[idx] : '0;
  assign xfer        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      dir_q   <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < N_WORDS; k++) buffer[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_valid) begin
            for (int k = 0; k < N_WORDS; k++)
              buffer[k] <= frame_data[k*WORD_W +: WORD_W];
            dir_q <= dir;
            idx   <= dir ? IDX_LAST : '0;
            cnt   <= '0;
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // A frame arriving while busy is dropped; the flag is sticky until reset.
          if (frame_valid) overrun <= 1'b1;
          if (xfer) begin
            if (is_last) begin
              idx   <= '0;
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              idx <= dir_q ? idx - 1'b1 : idx + 1'b1;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
